pushbutton_conditioner: RTL and testbench

- Input stage directly upstream of the Nibbler processor's 4-bit `pushbuttons` input. It synchronises and debounces four raw board buttons.
- The processor reads the debounced levels on `pushbuttons`.
- The block also provides one-cycle press pulses and per-button sticky press flags. Software-visible logic can clear each sticky flag individually.

---
 rtl/pushbutton_conditioner.sv | 70 +++++++
 tb/tb_pushbutton_conditioner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_conditioner.sv
// Synchronise, debounce and edge-detect four raw board buttons feeding the
// Nibbler `pushbuttons` input, with per-bit press pulses and sticky flags.
module pushbutton_conditioner #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic [3:0] clear_sticky,
  output logic [3:0] pushbuttons,
  output logic [3:0] press_pulse,
  output logic [3:0] sticky
);

  localparam int unsigned NB = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [NB-1:0]    pb_d;
  logic [NB-1:0]    pulse_d;
  logic [NB-1:0]    sticky_d;

  // Per-bit debounce: any agreement with the stable level restarts the count.
  always_comb begin
    pb_d    = pushbuttons;
    pulse_d = '0;
    for (int i = 0; i < int'(NB); i++) begin
      cnt_d[i] = '0;
    end
    for (int i = 0; i < int'(NB); i++) begin
      if (sync2[i] != pushbuttons[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          pb_d[i]    = sync2[i];
          pulse_d[i] = sync2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    // Set dominates clear so a press coinciding with a clear is not lost.
    sticky_d = (sticky & ~clear_sticky) | press_pulse;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1       <= '0;
      sync2       <= '0;
      pushbuttons <= '0;
      press_pulse <= '0;
      sticky      <= '0;
      for (int i = 0; i < int'(NB); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      pushbuttons <= pb_d;
      press_pulse <= pulse_d;
      sticky      <= sticky_d;
      for (int i = 0; i < int'(NB); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Directed self-checking bench for pushbutton_conditioner (default parameters).
module tb_pushbutton_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] clear_sticky;
  logic [3:0] pushbuttons;
  logic [3:0] press_pulse;
  logic [3:0] sticky;

  int n_checks = 0;
  int n_fail   = 0;

  pushbutton_conditioner dut (
    .clock        (clock),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .clear_sticky (clear_sticky),
    .pushbuttons  (pushbuttons),
    .press_pulse  (press_pulse),
    .sticky       (sticky)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Release all buttons long enough to settle; optionally clear sticky flags.
  task automatic settle(input bit clr);
    btn_raw = 4'b0000;
    clear_sticky = 4'b0000;
    for (int n = 0; n < 8; n++) step();
    if (clr) begin
      clear_sticky = 4'b1111;
      step();
      clear_sticky = 4'b0000;
    end
  endtask

  task automatic test_reset();
    logic [3:0] e_pb, e_pl, e_st;
    reset = 1'b0;
    btn_raw = 4'b1111;
    clear_sticky = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      step();
      n_checks++;
      if (pushbuttons !== 4'b0000 || press_pulse !== 4'b0000 || sticky !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold n=%0d got pb=%b pl=%b st=%b want all 0000", n, pushbuttons, press_pulse, sticky);
      end
    end
    reset = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step();
      e_pb = (n >= 6) ? 4'b1111 : 4'b0000;
      e_pl = (n == 6) ? 4'b1111 : 4'b0000;
      e_st = (n >= 7) ? 4'b1111 : 4'b0000;
      n_checks++;
      if (pushbuttons !== e_pb || press_pulse !== e_pl || sticky !== e_st) begin
        n_fail++;
        $display("FAIL reset_release n=%0d got pb=%b pl=%b st=%b want pb=%b pl=%b st=%b",
                 n, pushbuttons, press_pulse, sticky, e_pb, e_pl, e_st);
      end
    end
  endtask

  task automatic test_press_release();
    logic [3:0] e_pb, e_pl;
    settle(1'b1);
    btn_raw = 4'b0010;
    for (int n = 1; n <= 6; n++) begin
      step();
      e_pb = (n >= 6) ? 4'b0010 : 4'b0000;
      e_pl = (n == 6) ? 4'b0010 : 4'b0000;
      n_checks++;
      if (pushbuttons !== e_pb || press_pulse !== e_pl) begin
        n_fail++;
        $display("FAIL press n=%0d got pb=%b pl=%b want pb=%b pl=%b", n, pushbuttons, press_pulse, e_pb, e_pl);
      end
    end
    step();
    n_checks++;
    if (press_pulse !== 4'b0000 || sticky !== 4'b0010) begin
      n_fail++;
      $display("FAIL press_after got pl=%b st=%b want pl=0000 st=0010", press_pulse, sticky);
    end
    btn_raw = 4'b0000;
    for (int n = 1; n <= 6; n++) begin
      step();
      e_pb = (n >= 6) ? 4'b0000 : 4'b0010;
      n_checks++;
      if (pushbuttons !== e_pb || press_pulse !== 4'b0000 || sticky !== 4'b0010) begin
        n_fail++;
        $display("FAIL release n=%0d got pb=%b pl=%b st=%b want pb=%b pl=0000 st=0010",
                 n, pushbuttons, press_pulse, sticky, e_pb);
      end
    end
  endtask

  task automatic test_bounce();
    logic       lvl [8];
    logic [3:0] e_pb, e_pl;
    int         pulses;
    lvl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    settle(1'b1);
    for (int n = 0; n < 8; n++) begin
      btn_raw[0] = lvl[n];
      step();
      n_checks++;
      if (pushbuttons !== 4'b0000 || press_pulse !== 4'b0000) begin
        n_fail++;
        $display("FAIL bounce n=%0d got pb=%b pl=%b want 0000", n, pushbuttons, press_pulse);
      end
    end
    btn_raw[0] = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (press_pulse[0]) pulses++;
      e_pb = (n >= 6) ? 4'b0001 : 4'b0000;
      e_pl = (n == 6) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (pushbuttons !== e_pb || press_pulse !== e_pl) begin
        n_fail++;
        $display("FAIL bounce_settle n=%0d got pb=%b pl=%b want pb=%b pl=%b", n, pushbuttons, press_pulse, e_pb, e_pl);
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL bounce_pulse_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_sticky_race();
    settle(1'b0);
    btn_raw = 4'b0100;
    for (int n = 1; n <= 6; n++) step();
    n_checks++;
    if (press_pulse !== 4'b0100 || sticky !== 4'b0001) begin
      n_fail++;
      $display("FAIL race_pulse got pl=%b st=%b want pl=0100 st=0001", press_pulse, sticky);
    end
    clear_sticky = 4'b0100;
    step();
    n_checks++;
    if (sticky !== 4'b0101 || press_pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL race_set_wins got st=%b pl=%b want st=0101 pl=0000", sticky, press_pulse);
    end
    step();
    n_checks++;
    if (sticky !== 4'b0001) begin
      n_fail++;
      $display("FAIL race_clear got st=%b want 0001", sticky);
    end
    clear_sticky = 4'b1000;
    step();
    clear_sticky = 4'b0000;
    n_checks++;
    if (sticky !== 4'b0001) begin
      n_fail++;
      $display("FAIL clear_idle_bit got st=%b want 0001", sticky);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e_pb, e_pl, e_st;
    settle(1'b0);
    btn_raw = 4'b1000;
    for (int n = 0; n < 3; n++) step();
    reset = 1'b0;
    step();
    n_checks++;
    if (pushbuttons !== 4'b0000 || press_pulse !== 4'b0000 || sticky !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset got pb=%b pl=%b st=%b want all 0000", pushbuttons, press_pulse, sticky);
    end
    reset = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step();
      e_pb = (n >= 6) ? 4'b1000 : 4'b0000;
      e_pl = (n == 6) ? 4'b1000 : 4'b0000;
      e_st = (n >= 7) ? 4'b1000 : 4'b0000;
      n_checks++;
      if (pushbuttons !== e_pb || press_pulse !== e_pl || sticky !== e_st) begin
        n_fail++;
        $display("FAIL mid_requal n=%0d got pb=%b pl=%b st=%b want pb=%b pl=%b st=%b",
                 n, pushbuttons, press_pulse, sticky, e_pb, e_pl, e_st);
      end
    end
  endtask

  task automatic test_independence();
    logic [3:0] e_pb, e_pl, e_st;
    settle(1'b1);
    btn_raw = 4'b0001;
    for (int n = 1; n <= 9; n++) begin
      step();
      e_pb = {(n >= 8), 2'b00, (n >= 6)};
      e_pl = {(n == 8), 2'b00, (n == 6)};
      e_st = {(n >= 9), 2'b00, (n >= 7)};
      n_checks++;
      if (pushbuttons !== e_pb || press_pulse !== e_pl || sticky !== e_st) begin
        n_fail++;
        $display("FAIL indep n=%0d got pb=%b pl=%b st=%b want pb=%b pl=%b st=%b",
                 n, pushbuttons, press_pulse, sticky, e_pb, e_pl, e_st);
      end
      if (n == 2) btn_raw = 4'b1001;
    end
  endtask

  initial begin
    reset = 1'b0;
    btn_raw = 4'b0000;
    clear_sticky = 4'b0000;
    test_reset();
    test_press_release();
    test_bounce();
    test_sticky_race();
    test_reset_mid();
    test_independence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
